// File: rtl/qspi_host_loader.sv
// Frame parser feeding the QSPI slave buffer RAM port-B loader.
// Frame: SYNC, addr, len, payload[len], xor(addr, len, payload); one en pulse per payload byte.
module qspi_host_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned EN_HIGH   = 2,
    parameter int unsigned EN_LOW    = 1,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic       clk100m,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] addrin,
    output logic [7:0] datain,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned PhW   = 8;
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StHunt, StAddr, StLen, StData, StWrHi, StWrLo, StCsum
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       addrin_q, addrin_d;
    logic [7:0]       datain_q, datain_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [PhW-1:0]   phase_q, phase_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             accept;
    logic             timed;

    // Backpressure while a write strobe is in flight; held low throughout reset.
    assign s_ready  = !rst && (state_q != StWrHi) && (state_q != StWrLo);
    assign accept   = s_valid && s_ready;
    assign timed    = (state_q == StAddr) || (state_q == StLen) ||
                      (state_q == StData) || (state_q == StCsum);
    assign busy     = (state_q != StHunt);
    assign addrin   = addrin_q;
    assign datain   = datain_q;
    assign en       = en_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        addrin_d   = addrin_q;
        datain_d   = datain_q;
        en_d       = en_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        phase_d    = phase_q;
        idle_d     = idle_q;

        case (state_q)
            StHunt: begin
                if (accept && s_data == SYNC_BYTE) state_d = StAddr;
            end
            StAddr: begin
                if (accept) begin
                    ptr_d   = s_data;
                    csum_d  = s_data;
                    state_d = StLen;
                end
            end
            StLen: begin
                if (accept) begin
                    cnt_d   = s_data;
                    csum_d  = csum_q ^ s_data;
                    state_d = (s_data == 8'h00) ? StCsum : StData;
                end
            end
            StData: begin
                if (accept) begin
                    addrin_d = ptr_q;
                    datain_d = s_data;
                    en_d     = 1'b1;
                    csum_d   = csum_q ^ s_data;
                    phase_d  = '0;
                    state_d  = StWrHi;
                end
            end
            StWrHi: begin
                if (phase_q == PhW'(EN_HIGH - 1)) begin
                    en_d    = 1'b0;
                    phase_d = '0;
                    state_d = StWrLo;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StWrLo: begin
                if (phase_q == PhW'(EN_LOW - 1)) begin
                    ptr_d   = ptr_q + 8'd1;
                    cnt_d   = cnt_q - 8'd1;
                    phase_d = '0;
                    state_d = (cnt_q == 8'd1) ? StCsum : StData;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StCsum: begin
                if (accept) begin
                    if (s_data == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end
                    state_d = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase

        // An accepted byte in the timeout cycle takes precedence over the abort.
        if (accept) begin
            idle_d = '0;
        end else if (timed) begin
            if (idle_q == IdleW'(TIMEOUT - 1)) begin
                err_d      = 1'b1;
                err_code_d = 2'b10;
                idle_d     = '0;
                state_d    = StHunt;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            state_q    <= StHunt;
            ptr_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            addrin_q   <= '0;
            datain_q   <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            phase_q    <= '0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            addrin_q   <= addrin_d;
            datain_q   <= datain_d;
            en_q       <= en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            phase_q    <= phase_d;
            idle_q     <= idle_d;
        end
    end

endmodule

// File: tb/tb_qspi_host_loader.sv
// Bench for qspi_host_loader: frame-level reference model (expected writes and outcomes)
// plus a per-cycle monitor for the en strobe protocol.
module tb_qspi_host_loader;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] addrin;
    logic [7:0] datain;
    logic       en;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    qspi_host_loader #(
        .SYNC_BYTE(8'hA5),
        .EN_HIGH  (2),
        .EN_LOW   (1),
        .TIMEOUT  (TO)
    ) dut (
        .clk100m (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .addrin  (addrin),
        .datain  (datain),
        .en      (en),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_code(err_code)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] wq[$];    // expected writes {addr, data}
    int          eq[$];    // expected outcomes: 0 done, 1 err csum, 2 err timeout
    logic [15:0] wlog[$];  // observed writes
    logic [7:0]  pl[$];    // payload of the frame being sent
    bit          abort = 0;
    int          nwrites = 0;

    function automatic void check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Per-cycle monitor, sampled on the falling edge.
    logic       en_prev = 1'b0;
    int         hi_len = 0;
    int         lo_len = 1000;
    logic [7:0] ha = 8'h00;
    logic [7:0] hd = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            en_prev = 1'b0;
            hi_len  = 0;
            lo_len  = 1000;
        end else begin
            if (en) begin
                if (!en_prev) begin
                    check("en_low_gap", (lo_len >= 1) ? 1 : 0, 1);
                    ha = addrin;
                    hd = datain;
                    nwrites++;
                    wlog.push_back({addrin, datain});
                    if (wq.size() == 0) begin
                        check("unexpected_write", int'({addrin, datain}), -1);
                    end else begin
                        check("write", int'({addrin, datain}), int'(wq.pop_front()));
                    end
                    hi_len = 0;
                end
                hi_len++;
                check("hold_during_en", int'({addrin, datain}), int'({ha, hd}));
                check("s_ready_during_write", int'(s_ready), 0);
            end else begin
                if (en_prev) begin
                    check("en_high_len", hi_len, 2);
                    check("hold_after_fall", int'({addrin, datain}), int'({ha, hd}));
                    check("s_ready_after_fall", int'(s_ready), 0);
                    lo_len = 0;
                end
                lo_len++;
            end
            if (done && err) check("done_and_err", 1, 0);
            if (done || err) begin
                if (eq.size() == 0) begin
                    check("unexpected_outcome", done ? 0 : int'(err_code) + 16, -1);
                end else begin
                    check("frame_outcome", done ? 0 : int'(err_code), eq.pop_front());
                end
                check("busy_after_frame", int'(busy), 0);
            end
            en_prev = en;
        end
    end

    // Call on a falling edge; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        s_data = b;
        s_valid = 1'b1;
        while (!acc && !abort && n < 100) begin
            acc = s_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!acc && !abort) check("handshake_timeout", int'(b), -1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] a);
        logic [7:0] x;
        x = a ^ 8'(pl.size());
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    // Model: payload byte i lands at a+i (8-bit wrap); outcome by xor checksum.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] cs, input bit gaps);
        logic [7:0] ad;
        foreach (pl[i]) begin
            ad = a + 8'(i);
            wq.push_back({ad, pl[i]});
        end
        eq.push_back((cs == xsum(a)) ? 0 : 1);
        send_byte(8'hA5);
        if (gaps) idle($urandom_range(0, 4));
        if (!abort) send_byte(a);
        if (gaps) idle($urandom_range(0, 4));
        if (!abort) send_byte(8'(pl.size()));
        foreach (pl[i]) begin
            if (gaps) idle($urandom_range(0, 4));
            if (!abort) send_byte(pl[i]);
        end
        if (gaps) idle($urandom_range(0, 4));
        if (!abort) send_byte(cs);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wq.size() != 0 || eq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_writes_left", wq.size(), 0);
        check("drain_outcomes_left", eq.size(), 0);
        idle(2);
    endtask

    task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        pl.delete();
        pl.push_back(a);
        pl.push_back(b);
        pl.push_back(c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic [7:0] g;
        logic [7:0] a;
        logic [7:0] cs;

        repeat (3) @(negedge clk);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_en", int'(en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_err", int'({done, err}), 0);
        check("rst_addr_data", int'({addrin, datain}), 0);
        check("rst_err_code", int'(err_code), 0);
        rst = 1'b0;
        idle(2);
        check("idle_s_ready", int'(s_ready), 1);

        // 1: basic frame
        wlog.delete();
        set3(8'h11, 8'h22, 8'h33);
        run_frame(8'h10, 8'h13, 1'b0);
        drain();
        check("f1_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("f1_w0", int'(wlog[0]), 16'h1011);
            check("f1_w1", int'(wlog[1]), 16'h1122);
            check("f1_w2", int'(wlog[2]), 16'h1233);
        end

        // 2: address wrap
        wlog.delete();
        set3(8'hAA, 8'hBB, 8'hCC);
        run_frame(8'hFE, 8'h20, 1'b0);
        drain();
        check("f2_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("f2_w0", int'(wlog[0]), 16'hFEAA);
            check("f2_w1", int'(wlog[1]), 16'hFFBB);
            check("f2_w2", int'(wlog[2]), 16'h00CC);
        end

        // 3: bad checksum, writes still happen
        wlog.delete();
        set3(8'h11, 8'h22, 8'h33);
        run_frame(8'h10, 8'h14, 1'b0);
        drain();
        check("f3_nwrites", wlog.size(), 3);
        check("f3_err_code_held", int'(err_code), 1);

        // 4: garbage then empty frame
        wlog.delete();
        send_byte(8'h00);
        send_byte(8'h7F);
        pl.delete();
        run_frame(8'h40, 8'h40, 1'b0);
        drain();
        check("f4_nwrites", wlog.size(), 0);

        // 5: timeout after addr, then a good frame
        eq.push_back(2);
        send_byte(8'hA5);
        send_byte(8'h10);
        s_valid = 1'b0;
        n = 0;
        while (!err && n < TO + 5) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency_ok", (n >= TO - 1 && n <= TO + 1) ? 1 : 0, 1);
        check("timeout_err_code", int'(err_code), 2);
        drain();
        wlog.delete();
        set3(8'h11, 8'h22, 8'h33);
        run_frame(8'h10, 8'h13, 1'b0);
        drain();
        check("f5_nwrites", wlog.size(), 3);

        // Random frames with garbage and gaps
        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g);
            end
            pl.delete();
            for (int k = 0; k < int'($urandom_range(0, 6)); k++) pl.push_back(8'($urandom));
            a = 8'($urandom);
            cs = xsum(a);
            if ($urandom_range(0, 3) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
            run_frame(a, cs, f[0]);
            drain();
        end

        // 6: back-to-back frame, reset during the 2nd write
        base = nwrites;
        set3(8'h11, 8'h22, 8'h33);
        fork
            run_frame(8'h10, 8'h13, 1'b0);
            begin
                n = 0;
                while (nwrites < base + 2 && n < 100) begin
                    @(negedge clk);
                    #2;
                    n++;
                end
                check("second_write_seen", (nwrites >= base + 2) ? 1 : 0, 1);
                rst = 1'b1;
                abort = 1;
                #1;
                check("rst_mid_en", int'(en), 0);
                check("rst_mid_busy", int'(busy), 0);
                check("rst_mid_s_ready", int'(s_ready), 0);
                wq.delete();
                eq.delete();
            end
        join
        @(negedge clk);
        rst = 1'b0;
        abort = 0;
        idle(20);
        check("post_rst_writes", nwrites, base + 2);
        check("post_rst_en", int'(en), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
